// File: rtl/imem_fetch_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_responder_if
// Purpose  : Bundles the instruction-fetch handshake from the PC and the
//            simple read/busy bus to instruction memory.
// Signals  : pc, fetch_req, flush       PC -> responder
//            instr, iready, ifault      responder -> PC
//            mem_addr, mem_read         responder -> memory
//            mem_rdata, mem_busy        memory -> responder
// Modports : slave  - the fetch responder
//            master - the environment (PC plus instruction memory)
// Revision : 1.0 - initial release
// ============================================================================
interface imem_fetch_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] pc;
   logic              fetch_req;
   logic              flush;
   logic [DATA_W-1:0] instr;
   logic              iready;
   logic              ifault;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_busy;

   modport slave (
      input  pc, fetch_req, flush, mem_rdata, mem_busy,
      output instr, iready, ifault, mem_addr, mem_read
   );

   modport master (
      output pc, fetch_req, flush, mem_rdata, mem_busy,
      input  instr, iready, ifault, mem_addr, mem_read
   );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_responder
// Purpose  : Responder end of the PC instruction-fetch handshake. Serves the
//            instruction at pc either from a one-word fetch buffer (hit) or
//            by reading instruction memory over a read/busy bus (miss), and
//            reports it with a one-cycle iready pulse. Misaligned pc or a
//            bus that stays busy for TIMEOUT cycles yields a one-cycle
//            ifault pulse.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - imem_fetch_responder_if.slave
//                   (pc, fetch_req, flush, instr, iready, ifault,
//                    mem_addr, mem_read, mem_rdata, mem_busy)
// Params   : ADDR_W  - fetch/bus address width
//            DATA_W  - instruction/bus data width
//            TIMEOUT - max consecutive busy cycles in WAIT before fault (>=1)
// Options  : PREFETCH_EN - when defined, adds a next-line buffer entry that
//            is filled with buf_addr+4 while the PC is not requesting.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_responder #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  wire logic              clk,
   input  wire logic              rst,
   imem_fetch_responder_if.slave  bus
);

   // Counter is wide enough to hold the value TIMEOUT itself.
   localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
   localparam logic [ADDR_W-1:0]  c_LINE    = ADDR_W'(4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_RESP  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t            r_state;

   // Registered outputs
   logic              r_iready;
   logic              r_ifault;
   logic              r_mem_read;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_instr;

   // Demand fetch buffer
   logic              r_buf_valid;
   logic [ADDR_W-1:0] r_buf_addr;
   logic [DATA_W-1:0] r_buf_data;

   // WAIT bookkeeping
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_discard;

   // Combinational decode
   logic               w_misaligned;
   logic               w_hit_buf;
   logic               w_hit_nl;
   logic               w_pf_active;
   logic               w_discard;
   logic [c_CNT_W-1:0] w_cnt_next;

`ifdef PREFETCH_EN
   // Next-line entry and the prefetch that fills it
   logic              r_nl_valid;
   logic [ADDR_W-1:0] r_nl_addr;
   logic [DATA_W-1:0] r_nl_data;
   logic              r_pf_pend;    // a delivery happened; next line wanted
   logic [ADDR_W-1:0] r_pf_addr;
   logic              r_pf_active;  // the WAIT in progress is a prefetch

   assign w_hit_nl    = r_nl_valid && (r_nl_addr == bus.pc);
   assign w_pf_active = r_pf_active;
`else
   assign w_hit_nl    = 1'b0;
   assign w_pf_active = 1'b0;
`endif

   assign w_misaligned = (bus.pc[1:0] != 2'b00);
   assign w_hit_buf    = r_buf_valid && (r_buf_addr == bus.pc);
   // A flush on the completing edge abandons the fetch just like an
   // earlier flush, so the response is suppressed at the entry to RESP.
   assign w_discard    = r_discard || bus.flush;
   assign w_cnt_next   = r_cnt + c_CNT_W'(1);

   assign bus.iready   = r_iready;
   assign bus.ifault   = r_ifault;
   assign bus.mem_read = r_mem_read;
   assign bus.mem_addr = r_mem_addr;
   assign bus.instr    = r_instr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_iready    <= 1'b0;
         r_ifault    <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_addr  <= '0;
         r_instr     <= '0;
         r_buf_valid <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_data  <= '0;
         r_cnt       <= '0;
         r_discard   <= 1'b0;
`ifdef PREFETCH_EN
         r_nl_valid  <= 1'b0;
         r_nl_addr   <= '0;
         r_nl_data   <= '0;
         r_pf_pend   <= 1'b0;
         r_pf_addr   <= '0;
         r_pf_active <= 1'b0;
`endif
      end else begin
         case (r_state)
            // ------------------------------------------------------------
            S_IDLE: begin
               if (bus.fetch_req && !bus.flush) begin
                  if (w_misaligned) begin
                     // Misaligned: fault without touching the bus.
                     r_ifault <= 1'b1;
                     r_state  <= S_FAULT;
                  end else if (w_hit_buf) begin
                     r_iready <= 1'b1;
                     r_instr  <= r_buf_data;
                     r_state  <= S_RESP;
`ifdef PREFETCH_EN
                     r_pf_pend <= 1'b1;
                     r_pf_addr <= bus.pc + c_LINE;
`endif
                  end else if (w_hit_nl) begin
`ifdef PREFETCH_EN
                     // Promote the next-line word into the demand entry so
                     // the following prefetch may reuse the next-line slot.
                     r_iready    <= 1'b1;
                     r_instr     <= r_nl_data;
                     r_buf_valid <= 1'b1;
                     r_buf_addr  <= r_nl_addr;
                     r_buf_data  <= r_nl_data;
                     r_pf_pend   <= 1'b1;
                     r_pf_addr   <= bus.pc + c_LINE;
                     r_state     <= S_RESP;
`endif
                  end else begin
                     r_mem_addr  <= bus.pc;
                     r_mem_read  <= 1'b1;
                     r_cnt       <= '0;
                     r_discard   <= 1'b0;
`ifdef PREFETCH_EN
                     r_pf_active <= 1'b0;
`endif
                     r_state     <= S_WAIT;
                  end
               end
`ifdef PREFETCH_EN
               else if (!bus.fetch_req && r_pf_pend) begin
                  r_mem_addr  <= r_pf_addr;
                  r_mem_read  <= 1'b1;
                  r_cnt       <= '0;
                  r_discard   <= 1'b0;
                  r_pf_pend   <= 1'b0;
                  r_pf_active <= 1'b1;
                  r_state     <= S_WAIT;
               end
`endif
            end

            // ------------------------------------------------------------
            // mem_read/mem_addr stay put until an edge sees mem_busy=0 (or
            // the timeout fires), whatever flush does meanwhile.
            S_WAIT: begin
               if (!bus.mem_busy) begin
                  r_mem_read <= 1'b0;
                  r_discard  <= 1'b0;
                  if (w_pf_active) begin
`ifdef PREFETCH_EN
                     r_nl_valid  <= 1'b1;
                     r_nl_addr   <= r_mem_addr;
                     r_nl_data   <= bus.mem_rdata;
                     r_pf_active <= 1'b0;
`endif
                     r_state <= S_IDLE;
                  end else begin
                     r_buf_valid <= 1'b1;
                     r_buf_addr  <= r_mem_addr;
                     r_buf_data  <= bus.mem_rdata;
                     if (w_discard) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_iready <= 1'b1;
                        r_instr  <= bus.mem_rdata;
                        r_state  <= S_RESP;
`ifdef PREFETCH_EN
                        r_pf_pend <= 1'b1;
                        r_pf_addr <= r_mem_addr + c_LINE;
`endif
                     end
                  end
               end else if (w_cnt_next == c_TIMEOUT) begin
                  // Bus stuck: give up, buffer left as it was.
                  r_mem_read <= 1'b0;
                  r_discard  <= 1'b0;
                  if (w_pf_active) begin
`ifdef PREFETCH_EN
                     // A failed prefetch is silent; just drop the entry.
                     r_nl_valid  <= 1'b0;
                     r_pf_active <= 1'b0;
`endif
                     r_state <= S_IDLE;
                  end else if (w_discard) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_ifault <= 1'b1;
                     r_state  <= S_FAULT;
                  end
               end else begin
                  r_cnt <= w_cnt_next;
                  // A prefetch is never abandoned by a redirect.
                  if (bus.flush && !w_pf_active) begin
                     r_discard <= 1'b1;
                  end
               end
            end

            // ------------------------------------------------------------
            // iready/ifault were raised on entry; each lasts one cycle and
            // the extra state keeps responses at least two cycles apart.
            S_RESP: begin
               r_iready <= 1'b0;
               r_state  <= S_IDLE;
            end

            S_FAULT: begin
               r_ifault <= 1'b0;
               r_state  <= S_IDLE;
            end

            default: begin
               r_iready   <= 1'b0;
               r_ifault   <= 1'b0;
               r_mem_read <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_responder
// Purpose  : Self-checking bench for imem_fetch_responder. A transaction-level
//            model of the fetch buffer predicts the per-cycle outputs; one
//            compare process checks them on every falling edge, and literal
//            latency/data expectations pin the model.
// Options  : PREFETCH_EN - bench follows the next-line prefetch behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_responder;

   localparam int TO = 8;

   logic tb_clk = 1'b0;
   logic rst    = 1'b1;
   always #5 tb_clk = ~tb_clk;

   imem_fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   imem_fetch_responder #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(TO)
   ) dut (
      .clk(tb_clk),
      .rst(rst),
      .bus(bus)
   );

   // Instruction memory contents
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h10) return 32'h0050_0093;
      return (a << 8) ^ a ^ 32'hA500_0013;
   endfunction

   always_comb bus.mem_rdata = mem_word(bus.mem_addr);

   // Counters
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state
   logic        chk_on     = 1'b0;
   logic        m_iready   = 1'b0;
   logic        m_ifault   = 1'b0;
   logic        m_mem_read = 1'b0;
   logic [31:0] m_mem_addr = '0;
   logic [31:0] m_instr    = '0;
   logic        b_valid    = 1'b0;
   logic [31:0] b_addr     = '0;
   logic [31:0] b_data     = '0;
   logic        nl_valid   = 1'b0;
   logic [31:0] nl_addr    = '0;
   logic [31:0] nl_data    = '0;
   logic        pf_pend    = 1'b0;
   logic        pf_busy    = 1'b0;
   logic [31:0] pf_addr    = '0;

   int cyc      = 0;
   int resp_cnt = 0;
   int resp_cyc = 0;

   always @(posedge tb_clk) cyc <= cyc + 1;

   // Single compare process against the model
   always @(negedge tb_clk) begin
      if (chk_on && !rst) begin
         chk("iready", 64'(bus.iready), 64'(m_iready));
         chk("ifault", 64'(bus.ifault), 64'(m_ifault));
         chk("mem_read", 64'(bus.mem_read), 64'(m_mem_read));
         if (m_mem_read) chk("mem_addr", 64'(bus.mem_addr), 64'(m_mem_addr));
         chk("instr", 64'(bus.instr), 64'(m_instr));
         chk("resp_exclusive", 64'(bus.iready & bus.ifault), 64'(0));
         if (bus.iready || bus.ifault) begin
            resp_cnt = resp_cnt + 1;
            resp_cyc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic deliver(input logic [31:0] a, input logic [31:0] d);
      m_iready = 1'b1;
      m_instr  = d;
`ifdef PREFETCH_EN
      pf_pend = 1'b1;
      pf_addr = a + 32'd4;
`else
      if (a == 32'hFFFF_FFFF) pf_pend = 1'b0;
`endif
   endtask

   task automatic idle(input int n);
      bus.fetch_req = 1'b0;
      bus.flush     = 1'b0;
      bus.mem_busy  = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         if (pf_busy) begin
            m_mem_read = 1'b0;
            nl_valid   = 1'b1;
            nl_addr    = pf_addr;
            nl_data    = mem_word(pf_addr);
            pf_busy    = 1'b0;
         end else if (pf_pend) begin
            m_mem_read = 1'b1;
            m_mem_addr = pf_addr;
            pf_pend    = 1'b0;
            pf_busy    = 1'b1;
         end
      end
   endtask

   // One demand fetch from IDLE. lat = cycles from the request edge to the
   // iready/ifault pulse, or -1 when no pulse appeared.
   task automatic do_fetch(input logic [31:0] a, input int nbusy, input bit fl, output int lat);
      int  e0;
      int  r0;
      int  seen;
      bit  cur;
      r0 = resp_cnt;
      bus.pc        = a;
      bus.fetch_req = 1'b1;
      bus.flush     = 1'b0;
      bus.mem_busy  = 1'b0;
      step();
      e0 = cyc;
      if (a[1:0] != 2'b00) begin
         m_ifault = 1'b1;
         bus.fetch_req = 1'b0;
         step();
         m_ifault = 1'b0;
      end else if (b_valid && b_addr == a) begin
         deliver(a, b_data);
         bus.fetch_req = 1'b0;
         step();
         m_iready = 1'b0;
      end else if (nl_valid && nl_addr == a) begin
         b_addr = nl_addr;
         b_data = nl_data;
         b_valid = 1'b1;
         deliver(a, nl_data);
         bus.fetch_req = 1'b0;
         step();
         m_iready = 1'b0;
      end else begin
         m_mem_read   = 1'b1;
         m_mem_addr   = a;
         bus.mem_busy = (nbusy > 0);
         bus.flush    = fl;
         if (fl) bus.fetch_req = 1'b0;
         seen = 0;
         for (int k = 0; k <= TO; k++) begin
            cur = bus.mem_busy;
            step();
            bus.flush = 1'b0;
            if (cur) begin
               seen++;
               if (seen == TO) begin
                  m_mem_read    = 1'b0;
                  m_ifault      = !fl;
                  bus.fetch_req = 1'b0;
                  bus.mem_busy  = 1'b0;
                  step();
                  m_ifault = 1'b0;
                  break;
               end
               bus.mem_busy = (seen < nbusy);
            end else begin
               m_mem_read = 1'b0;
               b_valid = 1'b1;
               b_addr  = a;
               b_data  = mem_word(a);
               if (!fl) deliver(a, b_data);
               bus.fetch_req = 1'b0;
               step();
               m_iready = 1'b0;
               break;
            end
         end
      end
      if (resp_cnt != r0) lat = resp_cyc - e0 + 1;
      else lat = -1;
   endtask

   int lat;

   initial begin
      bus.pc        = '0;
      bus.fetch_req = 1'b0;
      bus.flush     = 1'b0;
      bus.mem_busy  = 1'b0;

      // Reset values
      repeat (2) @(negedge tb_clk);
      chk("rst_iready", 64'(bus.iready), 64'(0));
      chk("rst_ifault", 64'(bus.ifault), 64'(0));
      chk("rst_mem_read", 64'(bus.mem_read), 64'(0));
      chk("rst_instr", 64'(bus.instr), 64'(0));
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
      step();
      rst    = 1'b0;
      chk_on = 1'b1;
      idle(2);

      // Zero-wait miss
      do_fetch(32'h10, 0, 1'b0, lat);
      chk("lat_miss_10", 64'(lat), 64'(2));
      chk("instr_10", 64'(bus.instr), 64'(32'h0050_0093));
      idle(3);

      // Hit on the same address, then the next word
      do_fetch(32'h10, 0, 1'b0, lat);
      chk("lat_hit_10", 64'(lat), 64'(1));
      idle(3);
      do_fetch(32'h14, 0, 1'b0, lat);
`ifdef PREFETCH_EN
      chk("lat_14", 64'(lat), 64'(1));
`else
      chk("lat_14", 64'(lat), 64'(2));
`endif
      idle(3);

      // Wait states
      do_fetch(32'h20, 3, 1'b0, lat);
      chk("lat_busy3_20", 64'(lat), 64'(5));
      idle(3);

      // Misaligned
      do_fetch(32'h22, 0, 1'b0, lat);
      chk("lat_misaligned", 64'(lat), 64'(1));
      chk("ifault_misaligned_instr_kept", 64'(bus.instr), 64'(mem_word(32'h20)));
      idle(3);

      // Timeout, then the same pc must go to the bus again
      do_fetch(32'h50, 100, 1'b0, lat);
      chk("lat_timeout", 64'(lat), 64'(TO + 1));
      idle(3);
      do_fetch(32'h50, 0, 1'b0, lat);
      chk("lat_after_timeout", 64'(lat), 64'(2));
      idle(3);

      // Flush during WAIT: access completes silently, then hits
      do_fetch(32'h30, 2, 1'b1, lat);
      chk("flush_no_resp", 64'(lat), 64'(-1));
      idle(3);
      do_fetch(32'h30, 0, 1'b0, lat);
      chk("lat_hit_after_flush", 64'(lat), 64'(1));
      chk("instr_30", 64'(bus.instr), 64'(mem_word(32'h30)));
      idle(3);

`ifdef PREFETCH_EN
      do_fetch(32'h40, 0, 1'b0, lat);
      chk("lat_miss_40", 64'(lat), 64'(2));
      idle(4);
      do_fetch(32'h44, 0, 1'b0, lat);
      chk("lat_prefetch_hit_44", 64'(lat), 64'(1));
      idle(3);
`endif

      // Asynchronous reset in the middle of a stalled access
      bus.pc        = 32'h60;
      bus.fetch_req = 1'b1;
      step();
      m_mem_read    = 1'b1;
      m_mem_addr    = 32'h60;
      bus.mem_busy  = 1'b1;
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_mem_read", 64'(bus.mem_read), 64'(0));
      chk("arst_iready", 64'(bus.iready), 64'(0));
      chk("arst_instr", 64'(bus.instr), 64'(0));
      chk("arst_mem_addr", 64'(bus.mem_addr), 64'(0));
      m_iready = 1'b0; m_ifault = 1'b0; m_mem_read = 1'b0;
      m_mem_addr = '0; m_instr = '0;
      b_valid = 1'b0; nl_valid = 1'b0; pf_pend = 1'b0; pf_busy = 1'b0;
      bus.fetch_req = 1'b0;
      bus.mem_busy  = 1'b0;
      step();
      step();
      rst = 1'b0;
      idle(2);
      do_fetch(32'h0, 0, 1'b0, lat);
      chk("lat_after_reset_miss", 64'(lat), 64'(2));
      chk("instr_0", 64'(bus.instr), 64'(32'hA500_0013));
      idle(2);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
